// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the shift sequencer and its Shifter.
// Operation encodings match the EX-stage req_op field.
package shift_pkg;

  localparam int   DATA_W      = 16;
  localparam logic SH_MODE_SLL = 1'b1;
  localparam logic SH_MODE_SRA = 1'b0;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE,
    PASS2,
    RESP
  } seq_state_t;

  // Keeps the low (DATA_W - amt) bits; used to turn an arithmetic right shift into a logical one.
  function automatic logic [DATA_W-1:0] low_mask(input logic [3:0] amt);
    return {DATA_W{1'b1}} >> amt;
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response valid-ready bundle between the EX stage and the shift sequencer.
// rsp_zero exists only when SHIFT_SEQ_ZERO_FLAG_EN is defined.
interface shift_sequencer_if;
  import shift_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_data;
  logic [3:0]        req_amt;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
  logic              rsp_zero;
`endif

  modport master (
    output req_valid, req_op, req_data, req_amt, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    , input rsp_zero
`endif
  );

  modport slave (
    input  req_valid, req_op, req_data, req_amt, rsp_ready,
    output req_ready, rsp_valid, rsp_data
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    , output rsp_zero
`endif
  );

endinterface

// File: rtl/shift_sequencer_shifter.sv
// Combinational 16-bit shifter: Mode=1 logical left, Mode=0 arithmetic right.
// Zero latency, no flow control.
module Shifter
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] Shift_In,
  input  logic [3:0]        Shift_Val,
  input  logic              Mode,
  output logic [DATA_W-1:0] Shift_Out
);

  assign Shift_Out = (Mode == SH_MODE_SLL) ? (Shift_In << Shift_Val)
                                           : $unsigned($signed(Shift_In) >>> Shift_Val);

endmodule

// File: rtl/shift_sequencer.sv
// Sequences one Shifter to perform SLL/SRA/SRL/ROR, one op in flight; 1 cycle (2 for ROR) to rsp_valid.
// Result held in RESP until rsp_ready; req_ready only in IDLE. Optional rsp_zero via SHIFT_SEQ_ZERO_FLAG_EN.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter bit ROR_ZERO_FAST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  shift_sequencer_if.slave   bus
);

  seq_state_t        state_q, state_nxt;
  shift_op_t         op_q, req_op_e;
  logic [DATA_W-1:0] data_q, tmp_q, rsp_q;
  logic [3:0]        amt_q;
  logic [DATA_W-1:0] sh_in, sh_out, p1_result, p2_result;
  logic [3:0]        sh_val;
  logic              sh_mode;
  logic              accept;
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
  logic              zero_q;
`endif

  assign req_op_e = shift_op_t'(bus.req_op);
  assign accept   = bus.req_valid && (state_q == IDLE);

  Shifter u_shifter (
    .Shift_In  (sh_in),
    .Shift_Val (sh_val),
    .Mode      (sh_mode),
    .Shift_Out (sh_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    sh_in     = '0;
    sh_val    = '0;
    sh_mode   = SH_MODE_SRA;
    p1_result = sh_out;
    case (state_q)
      IDLE: begin
        sh_in  = bus.req_data;
        sh_val = bus.req_amt;
        case (req_op_e)
          OP_SLL: sh_mode = SH_MODE_SLL;
          OP_SRA: sh_mode = SH_MODE_SRA;
          OP_SRL: begin
            sh_mode   = SH_MODE_SRA;
            p1_result = sh_out & low_mask(bus.req_amt);
          end
          OP_ROR: begin
            // Left shift by (16 - amt) isolates the bits that wrap into the top.
            sh_mode = SH_MODE_SLL;
            sh_val  = 4'(~bus.req_amt + 4'd1);
          end
          default: sh_mode = SH_MODE_SRA;
        endcase
        if (accept) begin
          if (req_op_e == OP_ROR && (bus.req_amt != 4'd0 || !ROR_ZERO_FAST))
            state_nxt = PASS2;
          else
            state_nxt = RESP;
        end
      end
      PASS2: begin
        sh_in     = data_q;
        sh_val    = amt_q;
        sh_mode   = SH_MODE_SRA;
        state_nxt = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign p2_result = (op_q == OP_ROR) ? ((sh_out & low_mask(amt_q)) | tmp_q) : sh_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_SLL;
      data_q <= '0;
      amt_q  <= '0;
      tmp_q  <= '0;
      rsp_q  <= '0;
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
      zero_q <= 1'b0;
`endif
    end else if (accept) begin
      op_q   <= req_op_e;
      data_q <= bus.req_data;
      amt_q  <= bus.req_amt;
      if (state_nxt == PASS2) begin
        tmp_q <= (bus.req_amt == 4'd0) ? '0 : sh_out;
      end else begin
        rsp_q <= p1_result;
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
        zero_q <= (p1_result == '0);
`endif
      end
    end else if (state_q == PASS2) begin
      rsp_q <= p2_result;
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
      zero_q <= (p2_result == '0);
`endif
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_q;
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
  assign bus.rsp_zero  = zero_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: vector table plus backpressure, reset and slow-ROR sequences.
module tb_shift_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  shift_sequencer_if sif ();
  shift_sequencer_if sif0 ();

  shift_sequencer #(.ROR_ZERO_FAST(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  shift_sequencer #(.ROR_ZERO_FAST(1'b0)) dut_slow (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif0.slave)
  );

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [3:0]  amt;
    logic [15:0] exp;
    int          lat;
    logic        zero;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int w;
    string tag;
    tag = $sformatf("vec%0d", idx);
    w = 0;
    while (!sif.req_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk({tag, "_ready_in"}, {31'd0, sif.req_ready}, 32'd1);
    sif.req_op    = v.op;
    sif.req_data  = v.data;
    sif.req_amt   = v.amt;
    sif.req_valid = 1'b1;
    sif.rsp_ready = 1'b1;
    @(posedge clk); #1;
    sif.req_valid = 1'b0;
    lat = 1;
    while (!sif.rsp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
    chk({tag, "_data"}, {16'd0, sif.rsp_data}, {16'd0, v.exp});
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    chk({tag, "_zero"}, {31'd0, sif.rsp_zero}, {31'd0, v.zero});
`endif
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, {31'd0, sif.rsp_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, sif.req_ready}, 32'd1);
  endtask

  task automatic run_slow(input logic [15:0] data, input logic [3:0] amt, input logic [15:0] exp,
                          input string tag);
    sif0.req_op    = 2'b10;
    sif0.req_data  = data;
    sif0.req_amt   = amt;
    sif0.req_valid = 1'b1;
    sif0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    sif0.req_valid = 1'b0;
    chk({tag, "_valid_c1"}, {31'd0, sif0.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid_c2"}, {31'd0, sif0.rsp_valid}, 32'd1);
    chk({tag, "_data"}, {16'd0, sif0.rsp_data}, {16'd0, exp});
    @(posedge clk); #1;
    chk({tag, "_ready_back"}, {31'd0, sif0.req_ready}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 16'h0001, 4'd15, 16'h8000, 1, 1'b0};
    vecs[1]  = '{2'b01, 16'h8000, 4'd4,  16'hF800, 1, 1'b0};
    vecs[2]  = '{2'b11, 16'h8000, 4'd4,  16'h0800, 1, 1'b0};
    vecs[3]  = '{2'b10, 16'h1234, 4'd4,  16'h4123, 2, 1'b0};
    vecs[4]  = '{2'b10, 16'h8001, 4'd1,  16'hC000, 2, 1'b0};
    vecs[5]  = '{2'b10, 16'hABCD, 4'd0,  16'hABCD, 1, 1'b0};
    vecs[6]  = '{2'b00, 16'h8000, 4'd1,  16'h0000, 1, 1'b1};
    vecs[7]  = '{2'b00, 16'h0001, 4'd1,  16'h0002, 1, 1'b0};
    vecs[8]  = '{2'b11, 16'hFFFF, 4'd15, 16'h0001, 1, 1'b0};
    vecs[9]  = '{2'b01, 16'h7FFF, 4'd15, 16'h0000, 1, 1'b1};
    vecs[10] = '{2'b10, 16'h0001, 4'd15, 16'h0002, 2, 1'b0};
    vecs[11] = '{2'b11, 16'h1234, 4'd0,  16'h1234, 1, 1'b0};

    rst_n = 1'b0;
    sif.req_valid  = 1'b0; sif.req_op  = 2'b00; sif.req_data  = '0; sif.req_amt  = '0; sif.rsp_ready  = 1'b0;
    sif0.req_valid = 1'b0; sif0.req_op = 2'b00; sif0.req_data = '0; sif0.req_amt = '0; sif0.rsp_ready = 1'b0;
    #22;
    chk("reset_req_ready", {31'd0, sif.req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, sif.rsp_valid}, 32'd0);
    chk("reset_rsp_data", {16'd0, sif.rsp_data}, 32'd0);
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    chk("reset_rsp_zero", {31'd0, sif.rsp_zero}, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Backpressure with a second request waiting behind the response.
    sif.req_op = 2'b01; sif.req_data = 16'hF000; sif.req_amt = 4'd8;
    sif.req_valid = 1'b1; sif.rsp_ready = 1'b0;
    @(posedge clk); #1;
    sif.req_op = 2'b00; sif.req_data = 16'h0001; sif.req_amt = 4'd1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_valid_%0d", c), {31'd0, sif.rsp_valid}, 32'd1);
      chk($sformatf("bp_data_%0d", c), {16'd0, sif.rsp_data}, {16'd0, 16'hFFF0});
      chk($sformatf("bp_req_ready_%0d", c), {31'd0, sif.req_ready}, 32'd0);
      if (c < 2) begin
        @(posedge clk); #1;
      end
    end
    sif.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_handshake_valid", {31'd0, sif.rsp_valid}, 32'd0);
    chk("bp_handshake_ready", {31'd0, sif.req_ready}, 32'd1);
    @(posedge clk); #1;
    sif.req_valid = 1'b0;
    chk("bp_pending_valid", {31'd0, sif.rsp_valid}, 32'd1);
    chk("bp_pending_data", {16'd0, sif.rsp_data}, {16'd0, 16'h0002});
    @(posedge clk); #1;
    chk("bp_pending_done", {31'd0, sif.rsp_valid}, 32'd0);

    // Fixed two-pass ROR build.
    run_slow(16'hABCD, 4'd0, 16'hABCD, "slow_ror0");
    run_slow(16'h1234, 4'd4, 16'h4123, "slow_ror4");

    // Reset while a ROR sits in its second pass.
    sif.req_op = 2'b10; sif.req_data = 16'h1234; sif.req_amt = 4'd4;
    sif.req_valid = 1'b1; sif.rsp_ready = 1'b1;
    @(posedge clk); #1;
    sif.req_valid = 1'b0;
    chk("mid_ror_in_pass2", {31'd0, sif.rsp_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_ror_rst_valid", {31'd0, sif.rsp_valid}, 32'd0);
    chk("mid_ror_rst_data", {16'd0, sif.rsp_data}, 32'd0);
    chk("mid_ror_rst_ready", {31'd0, sif.req_ready}, 32'd1);
    #4;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("no_stale_%0d", c), {31'd0, sif.rsp_valid}, 32'd0);
    end
    run_vec(vecs[7], 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
